// File: rtl/fifo_ctrl.sv
// Control block for a DEPTH-entry register-bank FIFO: head/tail pointers, occupancy
// count, one-hot write enables, registered read address and per-request ack/error status.
module fifo_ctrl #(
    parameter int DEPTH = 8,   // power of two, >= 2
    parameter int AW    = 3    // log2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [DEPTH-1:0] we,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_valid,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      data_count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        INIT,
        NO_OP,
        WRITE,
        WR_ERROR,
        READ,
        RD_ERROR
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW-1:0] rd_addr_reg, rd_addr_next;
    logic          full_reg, empty_reg;
    logic          wr_fire;

    // A push only reaches the bank when no pop competes and there is room.
    assign wr_fire = reset_n && wr_en && !rd_en && (count_reg < FULL_COUNT);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we[gi] = wr_fire && (head_reg == AW'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = NO_OP;
        head_next    = head_reg;
        tail_next    = tail_reg;
        count_next   = count_reg;
        rd_addr_next = rd_addr_reg;
        if (rd_en) begin
            if (count_reg != '0) begin
                state_next   = READ;
                rd_addr_next = tail_reg;
                tail_next    = tail_reg + AW'(1);
                count_next   = count_reg - (AW+1)'(1);
            end else begin
                state_next = RD_ERROR;
            end
        end else if (wr_en) begin
            if (count_reg < FULL_COUNT) begin
                state_next = WRITE;
                head_next  = head_reg + AW'(1);
                count_next = count_reg + (AW+1)'(1);
            end else begin
                state_next = WR_ERROR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= INIT;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            rd_addr_reg <= '0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
        end else begin
            state_reg   <= state_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            count_reg   <= count_next;
            rd_addr_reg <= rd_addr_next;
            full_reg    <= (count_next == FULL_COUNT);
            empty_reg   <= (count_next == '0);
        end
    end

    // One status bit per state; INIT and NO_OP report nothing.
    assign wr_ack     = (state_reg == WRITE);
    assign wr_err     = (state_reg == WR_ERROR);
    assign rd_ack     = (state_reg == READ);
    assign rd_err     = (state_reg == RD_ERROR);
    assign rd_valid   = (state_reg == READ);
    assign rd_addr    = rd_addr_reg;
    assign full       = full_reg;
    assign empty      = empty_reg;
    assign data_count = count_reg;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed plus randomized bench for fifo_ctrl against a queue-based FIFO occupancy model.
module tb_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             wr_en;
    logic             rd_en;
    logic [DEPTH-1:0] we;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid, wr_ack, wr_err, rd_ack, rd_err, full, empty;
    logic [AW:0]      data_count;

    fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
        .we(we), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
        .full(full), .empty(empty), .data_count(data_count)
    );

    always #5 clk = ~clk;

    // Model: the FIFO holds slot numbers; the slot written next advances per accepted push.
    int q[$];
    int wr_slot   = 0;
    int m_rd_addr = 0;
    int m_status  = 0;   // 0 none, 1 wr_ack, 2 wr_err, 3 rd_ack, 4 rd_err

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge: drive, check we mid-cycle, clock, check state.
    task automatic cycle(input logic w, input logic r, input logic rn);
        logic [31:0] exp_we;
        wr_en   = w;
        rd_en   = r;
        reset_n = rn;
        exp_we  = 0;
        if (rn && w && !r && q.size() < DEPTH) exp_we = 32'd1 << wr_slot;
        @(negedge clk);
        chk("we", 32'(we), exp_we);
        @(posedge clk);
        #1;
        if (!rn) begin
            q.delete();
            wr_slot   = 0;
            m_rd_addr = 0;
            m_status  = 0;
        end else if (r) begin
            if (q.size() > 0) begin
                m_rd_addr = q.pop_front();
                m_status  = 3;
            end else begin
                m_status = 4;
            end
        end else if (w) begin
            if (q.size() < DEPTH) begin
                q.push_back(wr_slot);
                wr_slot  = (wr_slot + 1) % DEPTH;
                m_status = 1;
            end else begin
                m_status = 2;
            end
        end else begin
            m_status = 0;
        end
        chk("wr_ack", 32'(wr_ack), 32'(m_status == 1));
        chk("wr_err", 32'(wr_err), 32'(m_status == 2));
        chk("rd_ack", 32'(rd_ack), 32'(m_status == 3));
        chk("rd_err", 32'(rd_err), 32'(m_status == 4));
        chk("rd_valid", 32'(rd_valid), 32'(m_status == 3));
        chk("rd_addr", 32'(rd_addr), 32'(m_rd_addr));
        chk("data_count", 32'(data_count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        @(posedge clk);
        #1;
        // Reset, then idle
        cycle(0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        // Fill, overflow
        for (int i = 0; i < 9; i++) cycle(1, 0, 1);
        // Drain, underflow
        for (int i = 0; i < 9; i++) cycle(0, 1, 1);
        // Wrap-around after reset
        cycle(0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1);
        // Simultaneous push and pop: pop wins
        cycle(0, 0, 0);
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        cycle(1, 1, 1);
        cycle(0, 0, 1);
        // Reset during a push
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        // Randomized phases: write-heavy, read-heavy, mixed
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 150; i++) begin
                logic w, r, rn;
                case (p)
                    0: begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 2); end
                    1: begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 7); end
                    default: begin w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
                endcase
                rn = ($urandom_range(0, 59) != 0);
                cycle(w, r, rn);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
